instr_fetch_unit: RTL
=====================

// Module: instr_fetch_unit
// PURPOSE
//  Fetch stage of the 5-stage RV32I core; produces the instruction stream the decode stage consumes.
//  Issues word requests to instruction memory (req/gnt, in-order rvalid), buffers responses in a small FIFO,
//  presents {instr, pc, pc4, prediction} to decode and obeys decode's stall and EX's flush/redirect.
// PARAMETERS
//  RESET_PC         32'h0000_0000  first fetch address after reset
//  FIFO_DEPTH       2              instruction buffer entries (power of 2, >=2)
//  MAX_OUTSTANDING  2              max granted-but-unanswered imem requests (>=1)
// PORTS
//  clock             in   1   core clock
//  reset             in   1   asynchronous, active-high reset
//  stall_ip          in   1   decode stall; head entry held while high
//  flush_ip          in   1   redirect request from EX (mispredict/jump)
//  redirect_pc_ip    in   32  new fetch PC, sampled when flush_ip=1; bits[1:0] forced to 0
//  imem_req_op       out  1   request valid
//  imem_addr_op      out  32  request word address
//  imem_gnt_ip       in   1   request accepted this cycle (req&gnt)
//  imem_rvalid_ip    in   1   response valid, in request order, >=1 cycle after grant
//  imem_rdata_ip     in   32  response instruction word
//  instr_data_valid_op out 1  FIFO head valid
//  instr_data_op     out  32  head instruction
//  pc_op             out  32  head PC
//  pc4_op            out  32  pc_op+4 (mod 2^32)
//  prediction_pt_op  out  1   head predicted-taken bit
// BEHAVIOUR
//  Reset (async): fetch_pc=RESET_PC, FIFO empty, outstanding=0, discard_cnt=0, state=IDLE; all outputs 0.
//  FSM: IDLE -> FETCH unconditionally on first clock after reset deassert (no request in IDLE).
//   FETCH: imem_req_op=1 iff outstanding+fifo_count < FIFO_DEPTH and outstanding < MAX_OUTSTANDING.
//    req&gnt: outstanding++, fetch_pc += 4 (wraps). Request held stable (addr unchanged) until granted.
//    rvalid (discard_cnt==0): push {rdata, pc_of_req, pred}; outstanding--.
//   flush_ip=1 (any state): FIFO cleared, fetch_pc=redirect_pc, discard_cnt=outstanding after this cycle's
//    grant/rvalid accounting (rvalid in flush cycle is dropped), grant in flush cycle also counted as discard;
//    state=DRAIN if discard_cnt>0 else FETCH. No request issued in the flush cycle.
//   DRAIN: imem_req_op=0; each rvalid decrements discard_cnt and outstanding, data dropped;
//    discard_cnt==0 -> FETCH. Further flush in DRAIN re-targets fetch_pc, stays DRAIN.
//  Output: instr_data_valid_op = FIFO non-empty; head popped when valid & !stall_ip & !flush_ip.
//   Push and pop same cycle allowed at full. Outputs come straight from FIFO head (no extra latency):
//   first instruction visible earliest 1 cycle after its rvalid.
//  Overflow impossible by credit rule; rvalid with outstanding==0 is a protocol error (assertion).
//  Per-entry PC tracked in a MAX_OUTSTANDING-deep PC queue alongside requests.
// CONFIGURATION
//  STATIC_BRANCH_PREDICT_EN defined: on push, if rdata[6:0]==7'b1100011 and B-imm sign bit (rdata[31])=1,
//   entry pred=1, fetch_pc=pc+B_IMM, younger outstanding requests discarded (DRAIN as for flush, FIFO kept).
//   flush_ip in same cycle overrides prediction.
//  Not defined: prediction_pt_op tied 0, purely sequential fetch.
// TESTING
//  Reset, gnt=1, rvalid 1 cycle later, stall=0 -> addrs 0,4,8,...; decode sees pc 0,4,8 with pc4 4,8,12.
//  FIFO full (stall=1, 2 entries) -> imem_req_op=0; release stall -> one pop/cycle, requests resume.
//  flush with redirect 0x100 and 2 outstanding -> both responses dropped, next req addr 0x100, DRAIN->FETCH.
//  redirect_pc 0x103 -> next fetch addr 0x100; fetch_pc 0xFFFF_FFFC -> next 0x0, pc4_op=0x0.
//  Reset asserted mid-stream with outstanding requests -> outputs 0 at once, restart at RESET_PC.
//  With STATIC_BRANCH_PREDICT_EN: branch at 0x20 with imm -16 -> prediction_pt_op=1, next fetch 0x10.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage for the 5-stage RV32I core.
// Issues word requests to instruction memory under a credit rule, tracks the
// PC of every outstanding request, buffers responses in a small FIFO and
// presents the FIFO head to decode. Flushes from EX redirect the fetch PC and
// discard any responses still in flight.
// Optional feature: define STATIC_BRANCH_PREDICT_EN to predict backward
// conditional branches as taken; without it fetch is purely sequential and
// prediction_pt_op stays 0.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH      = 2,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall_ip,
  input  logic        flush_ip,
  input  logic [31:0] redirect_pc_ip,
  output logic        imem_req_op,
  output logic [31:0] imem_addr_op,
  input  logic        imem_gnt_ip,
  input  logic        imem_rvalid_ip,
  input  logic [31:0] imem_rdata_ip,
  output logic        instr_data_valid_op,
  output logic [31:0] instr_data_op,
  output logic [31:0] pc_op,
  output logic [31:0] pc4_op,
  output logic        prediction_pt_op
);

  localparam int unsigned FA_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned PQ_W  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + MAX_OUTSTANDING + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN
  } state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        pred;
  } entry_t;

  state_e           state_q, state_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [CNT_W-1:0] out_q, out_d;
  logic [CNT_W-1:0] disc_q, disc_d;
  logic [CNT_W-1:0] fifo_cnt_q, fifo_cnt_d;
  logic [FA_W-1:0]  fifo_wr_q, fifo_wr_d;
  logic [FA_W-1:0]  fifo_rd_q, fifo_rd_d;
  logic [PQ_W-1:0]  pq_wr_q, pq_wr_d;
  logic [PQ_W-1:0]  pq_rd_q, pq_rd_d;
  logic             req_q, req_d;

  entry_t           fifo_mem [FIFO_DEPTH];
  logic [31:0]      pq_mem   [MAX_OUTSTANDING];

  entry_t           head;
  entry_t           push_entry;
  logic             head_valid;
  logic             fire;
  logic             push;
  logic             pop;
  logic             pq_push;

  function automatic logic [PQ_W-1:0] pq_inc(input logic [PQ_W-1:0] p);
    return (p == PQ_W'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

`ifdef STATIC_BRANCH_PREDICT_EN
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  function automatic logic [31:0] b_imm(input logic [31:0] w);
    return {{20{w[31]}}, w[7], w[30:25], w[11:8], 1'b0};
  endfunction
`endif

  assign head       = fifo_mem[fifo_rd_q];
  assign head_valid = (fifo_cnt_q != '0);
  assign fire       = req_q & imem_gnt_ip;

  // Next-state logic: request/response accounting, flush and drain handling.
  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    disc_d     = disc_q;
    fifo_wr_d  = fifo_wr_q;
    fifo_rd_d  = fifo_rd_q;
    fifo_cnt_d = fifo_cnt_q;
    pq_wr_d    = pq_wr_q;
    pq_rd_d    = pq_rd_q;
    push       = 1'b0;
    pq_push    = 1'b0;
    push_entry = '{instr: imem_rdata_ip, pc: pq_mem[pq_rd_q], pred: 1'b0};
    pop        = head_valid & ~stall_ip & ~flush_ip;
    // Outstanding count is the same in every state: grants add, responses retire.
    out_d      = out_q + CNT_W'(fire) - CNT_W'(imem_rvalid_ip);

    if (flush_ip) begin
      // Everything still in flight (including this cycle's grant) becomes a discard.
      fetch_pc_d = redirect_pc_ip & 32'hFFFF_FFFC;
      fifo_wr_d  = '0;
      fifo_rd_d  = '0;
      fifo_cnt_d = '0;
      pq_wr_d    = '0;
      pq_rd_d    = '0;
      disc_d     = out_d;
      state_d    = (out_d != '0) ? S_DRAIN : S_FETCH;
    end else begin
      unique case (state_q)
        S_IDLE: state_d = S_FETCH;
        S_FETCH: begin
          if (fire) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
            pq_push    = 1'b1;
            pq_wr_d    = pq_inc(pq_wr_q);
          end
          if (imem_rvalid_ip) begin
            push    = 1'b1;
            pq_rd_d = pq_inc(pq_rd_q);
`ifdef STATIC_BRANCH_PREDICT_EN
            if (imem_rdata_ip[6:0] == OPC_BRANCH && imem_rdata_ip[31]) begin
              // Backward branch: follow it and drop the younger sequential requests.
              push_entry.pred = 1'b1;
              fetch_pc_d      = pq_mem[pq_rd_q] + b_imm(imem_rdata_ip);
              pq_wr_d         = '0;
              pq_rd_d         = '0;
              disc_d          = out_d;
              state_d         = (out_d != '0) ? S_DRAIN : S_FETCH;
            end
`endif
          end
        end
        S_DRAIN: begin
          if (imem_rvalid_ip) begin
            disc_d = disc_q - 1'b1;
            if (disc_q == CNT_W'(1)) state_d = S_FETCH;
          end
        end
        default: state_d = S_IDLE;
      endcase

      if (push) fifo_wr_d = fifo_wr_q + 1'b1;
      if (pop)  fifo_rd_d = fifo_rd_q + 1'b1;
      fifo_cnt_d = fifo_cnt_q + CNT_W'(push) - CNT_W'(pop);
    end

    // Credit rule: never request more than the FIFO could absorb.
    req_d = (state_d == S_FETCH)
         && ((out_d + fifo_cnt_d) < CNT_W'(FIFO_DEPTH))
         && (out_d < CNT_W'(MAX_OUTSTANDING));
  end

  // Control state registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      out_q      <= '0;
      disc_q     <= '0;
      fifo_cnt_q <= '0;
      fifo_wr_q  <= '0;
      fifo_rd_q  <= '0;
      pq_wr_q    <= '0;
      pq_rd_q    <= '0;
      req_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      out_q      <= out_d;
      disc_q     <= disc_d;
      fifo_cnt_q <= fifo_cnt_d;
      fifo_wr_q  <= fifo_wr_d;
      fifo_rd_q  <= fifo_rd_d;
      pq_wr_q    <= pq_wr_d;
      pq_rd_q    <= pq_rd_d;
      req_q      <= req_d;
    end
  end

  // Instruction buffer and request-PC queue storage.
  always_ff @(posedge clock) begin
    // NOTE: storage is not reset; validity comes from the reset counters/pointers.
    if (push)    fifo_mem[fifo_wr_q] <= push_entry;
    if (pq_push) pq_mem[pq_wr_q]     <= fetch_pc_q;
  end

  assign imem_req_op         = req_q;
  assign imem_addr_op        = req_q ? fetch_pc_q : '0;
  assign instr_data_valid_op = head_valid;
  assign instr_data_op       = head_valid ? head.instr : '0;
  assign pc_op               = head_valid ? head.pc : '0;
  assign pc4_op              = head_valid ? head.pc + 32'd4 : '0;
  assign prediction_pt_op    = head_valid & head.pred;

  // A response with nothing outstanding means the memory broke the protocol.
  a_no_orphan_rvalid: assert property (@(posedge clock) disable iff (reset)
    imem_rvalid_ip |-> (out_q != '0));

endmodule
